// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencer state encoding and the
// RISC-V opcodes the decoder and hazard logic agree on.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MISS    = 2'd1,
        RECOVER = 2'd2
    } state_e;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_IARITH = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

endpackage

// File: rtl/sat_counter.sv
// Synchronous-clear up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Load-use, data-cache-miss and taken-branch sequencing for the 5-stage core,
// with saturating performance counters and a miss-stall watchdog.
module hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs1_i,
    input  logic [4:0]       ID_rs2_i,
    input  logic [4:0]       EX_rd_i,
    input  logic             EX_MemRead_i,
    input  logic             branch_taken_i,
    input  logic             mem_stall_i,
    output logic             NoOp_o,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             pipe_stall_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o,
    output logic [CNT_W-1:0] miss_count_o,
    output logic             timeout_o
);

    localparam int unsigned MR_W = $clog2(TIMEOUT + 1);
    localparam logic [MR_W-1:0] TIMEOUT_MR = MR_W'(TIMEOUT);

    state_e          state_q, state_d;
    logic            flush_pending_q, flush_pending_d;
    logic [MR_W-1:0] miss_run_q, miss_run_d;
    logic            timeout_q, timeout_d;
    logic            load_use;
    logic            miss_entry;

    always_comb begin
        load_use = EX_MemRead_i && (EX_rd_i != '0) &&
                   ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));

        NoOp_o          = 1'b0;
        PCWrite_o       = 1'b1;
        IFID_Write_o    = 1'b1;
        IFID_Flush_o    = 1'b0;
        pipe_stall_o    = 1'b0;
        state_d         = RUN;
        flush_pending_d = flush_pending_q;

        if (rst_i) begin
            NoOp_o          = 1'b1;
            PCWrite_o       = 1'b0;
            IFID_Write_o    = 1'b0;
            flush_pending_d = 1'b0;
        end else if (mem_stall_i) begin
            pipe_stall_o    = 1'b1;
            PCWrite_o       = 1'b0;
            IFID_Write_o    = 1'b0;
            state_d         = MISS;
            flush_pending_d = flush_pending_q | branch_taken_i;
        end else begin
            if (load_use) begin
                NoOp_o       = 1'b1;
                PCWrite_o    = 1'b0;
                IFID_Write_o = 1'b0;
            end
            // The first cycle after a miss defers any taken branch so that
            // the single flush lands in RECOVER.
            case (state_q)
                RUN: IFID_Flush_o = branch_taken_i & ~load_use;
                MISS: begin
                    state_d         = RECOVER;
                    flush_pending_d = flush_pending_q | (branch_taken_i & ~load_use);
                end
                RECOVER: begin
                    IFID_Flush_o    = (flush_pending_q | branch_taken_i) & ~load_use;
                    flush_pending_d = 1'b0;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        miss_run_d = '0;
        timeout_d  = 1'b0;
        if (!rst_i) begin
            if (mem_stall_i) begin
                miss_run_d = (miss_run_q == TIMEOUT_MR) ? miss_run_q : miss_run_q + MR_W'(1);
            end
            timeout_d = timeout_q | (miss_run_d == TIMEOUT_MR);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= RUN;
            flush_pending_q <= 1'b0;
            miss_run_q      <= '0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            miss_run_q      <= miss_run_d;
            timeout_q       <= timeout_d;
        end
    end

    assign timeout_o  = timeout_q;
    assign miss_entry = mem_stall_i & ~rst_i & (state_q != MISS);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .inc_i (~PCWrite_o & ~rst_i),
        .clr_i (rst_i),
        .cnt_o (stall_cycles_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .inc_i (IFID_Flush_o),
        .clr_i (rst_i),
        .cnt_o (flush_count_o)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk_i (clk_i),
        .inc_i (miss_entry),
        .clr_i (rst_i),
        .cnt_o (miss_count_o)
    );

endmodule
